// File: rtl/bcd_binary_seq_pkg.sv
// Shared types and constants for the BCD-to-binary sequential converter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package bcd_binary_seq_pkg;

    // FSM encodings for the converter controller.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Step counter width: covers up to 16 steps (DIGITS = 4).
    localparam int CNT_W = 5;

    // Reverse double-dabble nibble adjust: a nibble >= 8 after the shift gets 3 removed.
    localparam logic [3:0] ADJ_THRESH = 4'd8;
    localparam logic [3:0] ADJ_OFFSET = 4'd3;

    // Largest legal BCD digit.
    localparam logic [3:0] BCD_MAX = 4'd9;

    function automatic logic nibble_invalid(input logic [3:0] nib);
        return (nib > BCD_MAX);
    endfunction

endpackage

// File: rtl/bcd_binary_seq_digit_adj.sv
// Single-nibble reverse double-dabble adjust: values >= 8 drop by 3.
// Latency: combinational.
// Backpressure: none.
module bcd_digit_adj
    import bcd_binary_seq_pkg::*;
(
    input  logic [3:0] i_nib,
    output logic [3:0] o_nib
);

    assign o_nib = (i_nib >= ADJ_THRESH) ? (i_nib - ADJ_OFFSET) : i_nib;

endmodule

// File: rtl/bcd_binary_seq.sv
// Sequential packed-BCD to binary converter, one reverse double-dabble step per cycle.
// Latency: done 4*DIGITS cycles after start is captured; start is ignored while busy.
// Optional BCD_CHECK_EN: invalid digits skip the shift and report err with done one cycle after capture.
module bcd_binary_seq
    import bcd_binary_seq_pkg::*;
#(
    parameter int DIGITS = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   bcd_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bin_out,
    output logic                  err
);

    localparam int               W         = 4 * DIGITS;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(W - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [2*W-1:0]     r_work;     // {bcd, bin}
    logic [2*W-1:0]     w_shift;
    logic [2*W-1:0]     w_step;
    logic [CNT_W-1:0]   r_cnt;
    logic [W-1:0]       r_bin;
    logic               w_last;
    logic               w_capture;
    logic               w_abort;

    assign w_last    = (r_cnt == LAST_STEP);
    assign w_capture = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_shift   = r_work >> 1;

    // Binary half passes straight through; each BCD nibble is adjusted after the shift.
    assign w_step[W-1:0] = w_shift[W-1:0];
    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .i_nib (w_shift[W + 4*g +: 4]),
            .o_nib (w_step [W + 4*g +: 4])
        );
    end

`ifdef BCD_CHECK_EN
    logic r_bad;
    logic r_err;
    logic w_in_bad;

    // Flag any illegal digit present on the input at capture time.
    always_comb begin
        w_in_bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (nibble_invalid(bcd_in[4*i +: 4])) w_in_bad = 1'b1;
        end
    end

    // Remember whether the captured word was illegal; it cuts the SHIFT phase short.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_bad <= 1'b0;
            r_err <= 1'b0;
        end else if (w_capture) begin
            r_bad <= w_in_bad;
        end else if (r_state == ST_SHIFT) begin
            if (r_bad)       r_err <= 1'b1;
            else if (w_last) r_err <= 1'b0;
        end
    end

    assign w_abort = r_bad;
    assign err     = r_err;
`else
    assign w_abort = 1'b0;
    assign err     = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (start) w_state_nxt = ST_SHIFT;
            ST_SHIFT: if (w_abort || w_last) w_state_nxt = ST_DONE;
            ST_DONE:  w_state_nxt = start ? ST_SHIFT : ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Status outputs decoded from state; an aborted conversion never shows busy.
    always_comb begin
        busy = (r_state == ST_SHIFT) && !w_abort;
        done = (r_state == ST_DONE);
    end

    // Work register, step counter and result latch.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_work <= '0;
            r_cnt  <= '0;
            r_bin  <= '0;
        end else if (w_capture) begin
            r_work <= {bcd_in, {W{1'b0}}};
            r_cnt  <= '0;
        end else if (r_state == ST_SHIFT) begin
            if (w_abort) begin
                r_bin <= '0;
            end else begin
                r_work <= w_step;
                r_cnt  <= r_cnt + CNT_W'(1);
                if (w_last) r_bin <= w_step[W-1:0];
            end
        end
    end

    assign bin_out = r_bin;

endmodule
